// File: rtl/multi_cycle_shifter_pkg.sv
// Shared types and constants for the multi-cycle logical shifter.
package multi_cycle_shifter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_AMT_W = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/multi_cycle_shifter_if.sv
// Request and result valid/ready channels of the multi-cycle shifter.
interface multi_cycle_shifter_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_amt, in_dir, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/multi_cycle_shifter_shift_step.sv
// One-bit zero-filling logical shift in the requested direction.
module multi_cycle_shifter_shift_step
  import multi_cycle_shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] data_o
);

  // Single step left or right, vacated bit filled with zero
  always_comb begin
    data_o = data_i;
    if (dir_i == DIR_LEFT) begin
      data_o = {data_i[WIDTH-2:0], 1'b0};
    end else begin
      data_o = {1'b0, data_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multi_cycle_shifter.sv
// Iterative logical shifter: one bit per clock, one request in flight,
// valid/ready on both the request and result sides.
module multi_cycle_shifter
  import multi_cycle_shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic                clk,
  input  logic                rst,
  multi_cycle_shifter_if.slave bus,
  output logic                busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] amt_capped_s;
  logic [WIDTH-1:0] step_s;

  multi_cycle_shifter_shift_step #(.WIDTH(WIDTH)) u_step (
    .data_i (data_q),
    .dir_i  (dir_q),
    .data_o (step_s)
  );

  // Saturate the requested amount so we never iterate past WIDTH steps
  always_comb begin
    amt_capped_s = CNT_W'(WIDTH);
    if (int'(bus.in_amt) < WIDTH) begin
      amt_capped_s = CNT_W'(bus.in_amt);
    end else begin
      amt_capped_s = CNT_W'(WIDTH);
    end
  end

  // State, data, count and direction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic; in_ready is implied by being in IDLE
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          dir_d   = bus.in_dir;
          count_d = amt_capped_s;
          state_d = (amt_capped_s != '0) ? ST_SHIFT : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        data_d  = step_s;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_data  = data_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multi_cycle_shifter.sv
// Directed, table-driven bench for multi_cycle_shifter with hand-written
// backpressure and mid-operation reset sequences.
module tb_multi_cycle_shifter;
  import multi_cycle_shifter_pkg::*;

  logic clk;
  logic rst;
  logic busy;

  int checks = 0;
  int errors = 0;

  multi_cycle_shifter_if #(.WIDTH(4), .AMT_W(3)) bus ();

  multi_cycle_shifter #(.WIDTH(4), .AMT_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [2:0] amt;
    logic       dir;
    logic [3:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request with out_ready high and check latency, data and recovery
  task automatic run_req(input logic [3:0] d, input logic [2:0] a, input logic dir,
                         input logic [3:0] exp, input int lat_exp);
    int lat;
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amt    = a;
    bus.in_dir    = dir;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    bus.in_amt   = 3'd7;
    bus.in_dir   = ~dir;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(lat_exp));
    check("out_data", 32'(bus.out_data), 32'(exp));
    @(negedge clk);
    check("out_valid_pulse", 32'(bus.out_valid), 32'd0);
    check("in_ready_return", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{4'b1011, 3'd1, DIR_LEFT,  4'b0110, 2};
    vecs[1] = '{4'b1011, 3'd2, DIR_RIGHT, 4'b0010, 3};
    vecs[2] = '{4'b1011, 3'd0, DIR_LEFT,  4'b1011, 1};
    vecs[3] = '{4'b1011, 3'd0, DIR_RIGHT, 4'b1011, 1};
    vecs[4] = '{4'b1111, 3'd5, DIR_LEFT,  4'b0000, 5};
    vecs[5] = '{4'b1111, 3'd7, DIR_RIGHT, 4'b0000, 5};
    vecs[6] = '{4'b1001, 3'd4, DIR_RIGHT, 4'b0000, 5};
    vecs[7] = '{4'b0001, 3'd3, DIR_LEFT,  4'b1000, 4};
    vecs[8] = '{4'b1000, 3'd3, DIR_RIGHT, 4'b0001, 4};
    vecs[9] = '{4'b1101, 3'd1, DIR_RIGHT, 4'b0110, 2};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'b0000;
    bus.in_amt    = 3'd0;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].exp, vecs[i].lat);
    end

    // Backpressure: result holds while out_ready is low, extra request ignored
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'b0110;
    bus.in_amt    = 3'd1;
    bus.in_dir    = DIR_RIGHT;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd2);
    for (int c = 0; c < 3; c++) begin
      check("bp_out_valid_hold", 32'(bus.out_valid), 32'd1);
      check("bp_out_data_hold", 32'(bus.out_data), 32'(4'b0011));
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      bus.in_valid = (c == 1);
      bus.in_data  = 4'b1111;
      bus.in_amt   = 3'd2;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("bp_still_valid", 32'(bus.out_valid), 32'd1);
    check("bp_still_data", 32'(bus.out_data), 32'(4'b0011));
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake_done", 32'(bus.out_valid), 32'd0);
    check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("bp_no_capture", 32'(busy), 32'd0);

    // Reset in the middle of SHIFT discards the request
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1000;
    bus.in_amt   = 3'd3;
    bus.in_dir   = DIR_RIGHT;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_busy_clear", 32'(busy), 32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_out_data", 32'(bus.out_data), 32'd0);
    lat = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) lat++;
    end
    check("rst_mid_no_output", 32'(lat), 32'd0);

    run_req(4'b1000, 3'd3, DIR_RIGHT, 4'b0001, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/multi_cycle_shifter.md
Name: multi_cycle_shifter

Overview:
- Sequential logical shifter for multi-bit shift amounts. It applies a single-bit logical shift step once per clock, for as many cycles as the requested amount.
- It sits between a producer issuing (data, amount, direction) requests and a consumer of shifted words.
- Both sides use a valid/ready handshake.
- One request is in flight at a time; no pipelining.

Parameters:
- WIDTH, 4, data word width in bits
- AMT_W, 3, shift-amount field width (amount range 0..2^AMT_W-1)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- in_data  input  WIDTH  word to shift
- in_amt  input  AMT_W  shift amount
- in_dir  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB); zero fill both ways
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted word
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Single clock, reset synchronous and active-high. All registers update on the rising edge of clk only.
- Reset values: state=IDLE, data register=0, count=0, dir=0. Outputs: out_valid=0, out_data=0, busy=0. in_ready=0 while rst is high.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data and in_dir, and set count=min(in_amt, WIDTH).
  - Next state is SHIFT if the capped count is nonzero, otherwise DONE.
- SHIFT:
  - in_ready=0.
  - Each cycle: data <= data<<1 or data>>1 per the latched dir, zero-filled; count <= count-1.
  - Transition to DONE in the same cycle count goes from 1 to 0.
- DONE:
  - out_valid=1 and out_data=data register.
  - On out_ready: go to IDLE and deassert out_valid next cycle.
  - out_data and out_valid hold stable while out_ready=0.
- Latency: with acceptance edge at cycle N and capped count k, out_valid rises at cycle N+1+k. k=0 gives N+1.
- Throughput: at most one request per k+2 cycles. in_ready is low from the cycle after acceptance until the cycle after the output handshake.
- Amount >= WIDTH: capped at WIDTH iterations, so the result is all zeros. Never iterate more than WIDTH times.
- in_valid while not in IDLE: ignored, no capture. The producer must hold its request until in_ready.
- in_data/in_amt/in_dir changing after acceptance: no effect on the in-flight operation.
- out_ready asserted outside DONE: ignored.
- rst asserted in any state, including mid-SHIFT or DONE with out_valid high: the next edge forces the reset values. The in-flight result is discarded with no output handshake. in_ready=1 in the first cycle after rst deasserts.
- out_data is driven from the data register in every state. Consumers may only sample it when out_valid=1.

Decomposition:
- Shared package: state enum (IDLE, SHIFT, DONE), DIR_LEFT=1'b0, DIR_RIGHT=1'b1, default WIDTH/AMT_W constants.
- One natural sub-module: shift_step. It is purely combinational: WIDTH-bit input plus dir in, one-bit logical shift out, zero fill.
- The top level holds the FSM, count register and data register, and feeds the data register through shift_step.

Test Plan:
- in_data=4'b1011, in_amt=1, in_dir=0, out_ready=1: accepted at cycle N → out_valid at N+2, out_data=4'b0110, single-cycle pulse, in_ready=1 at N+3.
- in_data=4'b1011, in_amt=2, in_dir=1 → out_valid at N+3, out_data=4'b0010.
- in_data=4'b1011, in_amt=0, either dir → out_valid at N+1, out_data=4'b1011.
- in_data=4'b1111, in_amt=5, in_dir=0 → capped at 4 iterations, out_valid at N+5, out_data=4'b0000.
- Backpressure: 4'b0110, amt=1, dir=1, out_ready held low 3 cycles once out_valid rises → out_data=4'b0011 and out_valid stay stable 3 cycles. A second in_valid pulse during this time is not accepted (in_ready=0). The handshake completes on the cycle out_ready=1.
- Reset mid-operation: 4'b1000, amt=3, dir=1, rst pulsed high one cycle during SHIFT → out_valid never asserts for that request, busy=0 and in_ready=1 in the cycle after rst falls. A fresh request then completes normally.
